// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, requester IDs and default widths.
// The widths must match the memory bank that the arbiter drives.
package mem_arb_pkg;

   localparam int MEM_WIDTH      = 32;
   localparam int MEM_ADDR_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_e;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } req_id_e;

   function automatic req_id_e other_req(input req_id_e id);
      if (id == REQ_D) return REQ_IF;
      else             return REQ_D;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the arbiter plus the priority pointer (requester that wins a tie).
// MEM_ARB_RR_EN selects round-robin; otherwise the pointer stays on D (fixed priority).
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    if_req,
   input  logic    d_req,
   input  logic    grant_en,
   output logic    any_req,
   output req_id_e winner
);

   req_id_e ptr_q, ptr_d;

   always_comb begin
      any_req = if_req | d_req;
      if (if_req && d_req) winner = ptr_q;
      else if (d_req)      winner = REQ_D;
      else                 winner = REQ_IF;
   end

   always_comb begin
      ptr_d = ptr_q;
`ifdef MEM_ARB_RR_EN
      if (grant_en) ptr_d = other_req(winner);
`else
      // fixed priority: the tie-break pointer is pinned to D
      if (grant_en) ptr_d = REQ_D;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) ptr_q <= REQ_D;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IF fetch / D load-store) arbiter for a single-port word memory, one access in flight.
// Build option: define MEM_ARB_RR_EN for round-robin tie-break, else D has fixed priority over IF.
//
// state    | meaning
// ST_IDLE  | no access in flight; requests sampled on the next edge
// ST_ISSUE | latched addr/data presented to memory; winner's gnt high
// ST_WAIT  | read only: memory returns data, captured on the next edge
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH      = MEM_WIDTH,
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [WIDTH-1:0]      if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0]      d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [WIDTH-1:0]      d_rdata,
   output logic                  mem_mode,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]      mem_wdata,
   input  logic [WIDTH-1:0]      mem_rdata,
   output logic                  busy
);

   arb_state_e            state_q, state_d;
   req_id_e               win_q, win_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;
   logic [WIDTH-1:0]      if_rdata_q, if_rdata_d;
   logic [WIDTH-1:0]      d_rdata_q, d_rdata_d;
   logic                  if_rvalid_q, if_rvalid_d;
   logic                  d_rvalid_q, d_rvalid_d;

   logic    any_req;
   logic    grant_en;
   req_id_e winner;

   assign grant_en = (state_q == ST_IDLE) && any_req;

   mem_arb_pick u_pick (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .d_req    (d_req),
      .grant_en (grant_en),
      .any_req  (any_req),
      .winner   (winner)
   );

   always_ff @(posedge clk) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (any_req) state_d = ST_ISSUE;
         ST_ISSUE: state_d = we_q ? ST_IDLE : ST_WAIT;
         ST_WAIT:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      if_gnt   = (state_q == ST_ISSUE) && (win_q == REQ_IF);
      d_gnt    = (state_q == ST_ISSUE) && (win_q == REQ_D);
      mem_mode = (state_q == ST_ISSUE) && we_q;
      busy     = (state_q != ST_IDLE);
   end

   // Request fields are latched only on the grant edge, so mem_addr holds through WAIT and IDLE.
   always_comb begin
      win_d       = win_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      if (grant_en) begin
         win_d = winner;
         if (winner == REQ_D) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
         end else begin
            we_d    = 1'b0;
            addr_d  = if_addr;
         end
      end
      if (state_q == ST_WAIT) begin
         if (win_q == REQ_D) begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
         end else begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         win_q       <= REQ_IF;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
      end else begin
         win_q       <= win_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;

endmodule
